// File: rtl/alu_pkg.sv
// Shared ALU control codes, multiply/divide op encodings and the sequencer state type.
package alu_pkg;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_XOR = 3'b100;
    localparam logic [2:0] ALU_SLL = 3'b101;
    localparam logic [2:0] ALU_SRL = 3'b110;
    localparam logic [2:0] ALU_SLT = 3'b111;

    localparam logic [1:0] MD_OP_MUL  = 2'b00;
    localparam logic [1:0] MD_OP_DIVU = 2'b01;
    localparam logic [1:0] MD_OP_REMU = 2'b10;
    localparam logic [1:0] MD_OP_RSVD = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_MUL_STEP,
        ST_DIV_CMP,
        ST_DIV_SUB,
        ST_FINISH
    } md_state_t;

endpackage

// File: rtl/alu_muldiv_sequencer.sv
// Multi-cycle MUL/DIVU/REMU sequencer that borrows the shared ALU for every add, subtract and compare.
module alu_muldiv_sequencer
    import alu_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] opa,
    input  logic [WIDTH-1:0] opb,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             alu_req,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [2:0]       alu_ctrl,
    input  logic [WIDTH-1:0] alu_result,
    input  logic             alu_zero
);

    localparam int CNT_W = $clog2(WIDTH) + 1;
    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);
    localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    md_state_t        state_q, state_d;
    logic [1:0]       op_q, op_d;
    logic [WIDTH-1:0] divisor_q, divisor_d;
    logic [WIDTH-1:0] acc_q, acc_d;       // MUL accumulator / DIV remainder
    logic [WIDTH-1:0] sh_q, sh_d;         // MUL multiplicand / DIV quotient
    logic [WIDTH-1:0] mplier_q, mplier_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             c_q, c_d;
    logic             lt_q, lt_d;
    logic [WIDTH-1:0] result_q, result_d;

    logic [WIDTH-1:0] rem_shift;
    logic             carry;
    logic             unused_alu_zero;

    assign unused_alu_zero = alu_zero;
    assign rem_shift = {acc_q[WIDTH-2:0], sh_q[WIDTH-1]};
    assign carry     = acc_q[WIDTH-1];

    assign busy    = (state_q == ST_MUL_STEP) || (state_q == ST_DIV_CMP) || (state_q == ST_DIV_SUB);
    assign done    = (state_q == ST_FINISH);
    assign alu_req = busy;
    assign result  = result_q;

    always_comb begin
        alu_a    = '0;
        alu_b    = '0;
        alu_ctrl = ALU_ADD;
        case (state_q)
            ST_MUL_STEP: begin
                alu_a    = acc_q;
                alu_b    = sh_q;
                alu_ctrl = ALU_ADD;
            end
            ST_DIV_CMP: begin
                alu_a    = rem_shift;
                alu_b    = divisor_q;
                alu_ctrl = ALU_SLT;
            end
            ST_DIV_SUB: begin
                alu_a    = acc_q;
                alu_b    = divisor_q;
                alu_ctrl = ALU_SUB;
            end
            default: ;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        divisor_d = divisor_q;
        acc_d     = acc_q;
        sh_d      = sh_q;
        mplier_d  = mplier_q;
        cnt_d     = cnt_q;
        c_d       = c_q;
        lt_d      = lt_q;
        result_d  = result_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    op_d      = op;
                    divisor_d = opb;
                    cnt_d     = '0;
                    acc_d     = '0;
                    sh_d      = opa;
                    mplier_d  = opb;
                    case (op)
                        MD_OP_MUL: state_d = ST_MUL_STEP;
                        MD_OP_DIVU, MD_OP_REMU: begin
                            if (opb == '0) begin
                                result_d = (op == MD_OP_DIVU) ? '1 : opa;
                                state_d  = ST_FINISH;
                            end else begin
                                state_d = ST_DIV_CMP;
                            end
                        end
                        default: begin
                            result_d = '0;
                            state_d  = ST_FINISH;
                        end
                    endcase
                end
            end
            ST_MUL_STEP: begin
                if (mplier_q[0]) acc_d = alu_result;
                sh_d     = sh_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q + 1'b1;
                if (cnt_q == LAST_STEP) begin
                    result_d = acc_d;
                    state_d  = ST_FINISH;
                end
            end
            ST_DIV_CMP: begin
                acc_d   = rem_shift;
                c_d     = carry;
                lt_d    = (alu_result == ONE) && !carry;
                sh_d    = sh_q << 1;
                state_d = ST_DIV_SUB;
            end
            ST_DIV_SUB: begin
                // A set carry means the shifted remainder exceeds WIDTH bits, so it is never below the divisor.
                if (c_q || !lt_q) begin
                    acc_d   = alu_result;
                    sh_d[0] = 1'b1;
                end
                cnt_d   = cnt_q + 1'b1;
                state_d = ST_DIV_CMP;
                if (cnt_q == LAST_STEP) begin
                    result_d = (op_q == MD_OP_DIVU) ? sh_d : acc_d;
                    state_d  = ST_FINISH;
                end
            end
            ST_FINISH: state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            result_q <= '0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            result_q <= result_d;
            cnt_q    <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        op_q      <= op_d;
        divisor_q <= divisor_d;
        acc_q     <= acc_d;
        sh_q      <= sh_d;
        mplier_q  <= mplier_d;
        c_q       <= c_d;
        lt_q      <= lt_d;
    end

endmodule

// File: tb/tb_alu_muldiv_sequencer.sv
// Bench for alu_muldiv_sequencer: models the shared ALU and checks results/latency against plain arithmetic.
module tb_alu_muldiv_sequencer;
    import alu_pkg::*;

    localparam int W = 16;

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic [1:0]   op;
    logic [W-1:0] opa, opb;
    logic         busy, done, alu_req;
    logic [W-1:0] result, alu_a, alu_b, alu_result;
    logic [2:0]   alu_ctrl;
    logic         alu_zero;

    alu_muldiv_sequencer #(.WIDTH(W)) dut (
        .clk(clk), .reset(reset), .start(start), .op(op), .opa(opa), .opb(opb),
        .busy(busy), .done(done), .result(result), .alu_req(alu_req),
        .alu_a(alu_a), .alu_b(alu_b), .alu_ctrl(alu_ctrl),
        .alu_result(alu_result), .alu_zero(alu_zero)
    );

    always #5 clk = ~clk;

    always_comb begin
        case (alu_ctrl)
            ALU_ADD: alu_result = alu_a + alu_b;
            ALU_SUB: alu_result = alu_a - alu_b;
            ALU_SLT: alu_result = (alu_a < alu_b) ? 16'd1 : 16'd0;
            default: alu_result = '0;
        endcase
        alu_zero = (alu_result == '0);
    end

    int n_chk  = 0;
    int n_fail = 0;
    bit chk_en = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            chk("alu_req==busy", alu_req, busy);
            if (!busy) chk("alu_inputs_idle", {alu_ctrl, alu_a, alu_b}, 64'd0);
        end
    end

    function automatic logic [W-1:0] ref_result(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
        logic [31:0] prod;
        prod = 32'(a) * 32'(b);
        case (o)
            MD_OP_MUL:  return prod[W-1:0];
            MD_OP_DIVU: return (b == 0) ? 16'hFFFF : a / b;
            MD_OP_REMU: return (b == 0) ? a : a % b;
            default:    return '0;
        endcase
    endfunction

    function automatic int ref_lat(input logic [1:0] o, input logic [W-1:0] b);
        if (o == MD_OP_MUL) return W + 1;
        if ((o == MD_OP_DIVU || o == MD_OP_REMU) && b != 0) return 2 * W + 1;
        return 1;
    endfunction

    // Launch one op and follow it to done; checks busy shape, latency, result and single done pulse.
    task automatic run_op(input string tag, input logic [1:0] o, input logic [W-1:0] a,
                          input logic [W-1:0] b, input logic [W-1:0] exp, input int lat);
        int n;
        @(negedge clk);
        start = 1'b1; op = o; opa = a; opb = b;
        @(negedge clk);
        start = 1'b0; opa = W'($urandom); opb = W'($urandom);
        n = 1;
        while (!done && n < 100) begin
            chk({tag, " busy"}, busy, 1'b1);
            @(negedge clk);
            n++;
        end
        chk({tag, " latency"}, n, lat);
        chk({tag, " result"}, result, exp);
        chk({tag, " busy_at_done"}, busy, 1'b0);
        @(negedge clk);
        chk({tag, " done_pulse"}, done, 1'b0);
        chk({tag, " result_held"}, result, exp);
    endtask

    typedef struct {
        logic [1:0]   o;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] exp;
        int           lat;
    } vec_t;

    vec_t vecs[12];

    initial begin
        int n;
        vecs[0]  = '{MD_OP_MUL,  16'd3,      16'd5,      16'h000F, 17};
        vecs[1]  = '{MD_OP_MUL,  16'hFFFF,   16'hFFFF,   16'h0001, 17};
        vecs[2]  = '{MD_OP_MUL,  16'h1234,   16'h0000,   16'h0000, 17};
        vecs[3]  = '{MD_OP_MUL,  16'h00FF,   16'h0101,   16'hFFFF, 17};
        vecs[4]  = '{MD_OP_DIVU, 16'd100,    16'd7,      16'h000E, 33};
        vecs[5]  = '{MD_OP_REMU, 16'd100,    16'd7,      16'h0002, 33};
        vecs[6]  = '{MD_OP_DIVU, 16'hFFFF,   16'h8001,   16'h0001, 33};
        vecs[7]  = '{MD_OP_REMU, 16'hFFFF,   16'h8001,   16'h7FFE, 33};
        vecs[8]  = '{MD_OP_DIVU, 16'h8000,   16'h0001,   16'h8000, 33};
        vecs[9]  = '{MD_OP_DIVU, 16'h1234,   16'h0000,   16'hFFFF, 1};
        vecs[10] = '{MD_OP_REMU, 16'h1234,   16'h0000,   16'h1234, 1};
        vecs[11] = '{MD_OP_RSVD, 16'h5555,   16'h0003,   16'h0000, 1};

        reset = 1'b1; start = 1'b0; op = '0; opa = '0; opb = '0;
        repeat (3) @(negedge clk);
        chk("reset busy", busy, 1'b0);
        chk("reset done", done, 1'b0);
        chk("reset result", result, 16'h0);
        chk("reset alu", {alu_req, alu_ctrl, alu_a, alu_b}, 64'd0);
        reset = 1'b0;
        chk_en = 1'b1;

        foreach (vecs[i])
            run_op($sformatf("vec%0d", i), vecs[i].o, vecs[i].a, vecs[i].b, vecs[i].exp, vecs[i].lat);

        // start during a MUL and again during FINISH must both be ignored
        @(negedge clk);
        start = 1'b1; op = MD_OP_MUL; opa = 16'd3; opb = 16'd5;
        @(negedge clk);
        start = 1'b0;
        n = 1;
        repeat (4) @(negedge clk);
        n += 4;
        start = 1'b1; op = MD_OP_DIVU; opa = 16'd9; opb = 16'd3;
        @(negedge clk);
        start = 1'b0;
        n++;
        while (!done && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("ignore latency", n, 17);
        chk("ignore result", result, 16'h000F);
        start = 1'b1; op = MD_OP_MUL; opa = 16'd2; opb = 16'd2;
        @(negedge clk);
        start = 1'b0;
        chk("finish_start done", done, 1'b0);
        chk("finish_start busy", busy, 1'b0);
        @(negedge clk);
        chk("finish_start not_accepted", busy, 1'b0);
        chk("finish_start result", result, 16'h000F);

        // reset in the middle of a divide aborts without a done pulse
        start = 1'b1; op = MD_OP_DIVU; opa = 16'd100; opb = 16'd7;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        chk("abort busy_before", busy, 1'b1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("abort busy", busy, 1'b0);
        chk("abort done", done, 1'b0);
        chk("abort result", result, 16'h0);
        for (int k = 0; k < 40; k++) begin
            chk("abort no_done", done, 1'b0);
            @(negedge clk);
        end
        run_op("after_abort", MD_OP_MUL, 16'd2, 16'd3, 16'h0006, 17);

        for (int r = 0; r < 30; r++) begin
            logic [1:0]   ro;
            logic [W-1:0] ra, rb;
            ro = 2'($urandom_range(0, 3));
            ra = W'($urandom);
            case ($urandom_range(0, 3))
                0:       rb = '0;
                1:       rb = W'($urandom_range(1, 15));
                default: rb = W'($urandom);
            endcase
            run_op($sformatf("rand%0d", r), ro, ra, rb, ref_result(ro, ra, rb), ref_lat(ro, rb));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
